mem_rw_arbiter: RTL and testbench
=================================

Name: mem_rw_arbiter

Overview:
- Shares the single read/write port of main_mem between two requesters: the core's load/store path and the front-panel LOAD/LOOK buttons.
- Sits between the system top level and main_mem.
- Replaces the halted-CPU-only panel mux with a registered grant FSM.
- Latches one-cycle panel pulses into a request buffer, prevents core starvation of the panel, and returns panel read data in a holding register for the data LEDs.

Parameters:
- AW, 8, memory address width
- DW, 16, memory data width
- STARVE_LIMIT, 4, consecutive core grants allowed while a panel request waits before the panel is forced

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active high
- core_val_i  in  1  core request valid; held with wen/addr/wdata until core_rdy_o
- core_wen_i  in  1  core write enable
- core_addr_i  in  AW  core address
- core_wdata_i  in  DW  core write data
- core_rdata_o  out  DW  read data, valid when core_rdy_o=1
- core_rdy_o  out  1  one-cycle completion pulse to core
- pnl_en_i  in  1  panel access permitted (top level drives 1 when not running)
- pnl_load_i  in  1  LOAD button pulse: write pnl_data_i to pnl_addr_i
- pnl_look_i  in  1  LOOK button pulse: read pnl_addr_i
- pnl_addr_i  in  AW  address switches
- pnl_data_i  in  DW  data switches
- pnl_busy_o  out  1  panel request pending or in service
- pnl_done_o  out  1  one-cycle pulse, panel transaction finished
- pnl_rdata_o  out  DW  last panel result (look: read data; load: written data)
- mem_val_o  out  1  request to main_mem
- mem_wen_o  out  1  write enable to main_mem
- mem_addr_o  out  AW  address to main_mem
- mem_wdata_o  out  DW  write data to main_mem
- mem_rdata_i  in  DW  main_mem read data
- mem_rdy_i  in  1  main_mem completion pulse, any latency ≥1 cycle

Behaviour:
Reset (rst_i=1 at a clock edge):
- state=IDLE, panel buffer empty, starve count=0.
- pnl_rdata_o=0, pnl_done_o=0, pnl_busy_o=0, mem_val_o=0, core_rdy_o=0.
- Reset mid-transaction abandons the transaction; no rdy/done is issued for it.
- mem_rdy_i arriving after reset is ignored.

Panel buffer:
- In any cycle with pnl_en_i=1 and buffer empty, pnl_load_i or pnl_look_i captures {wen, pnl_addr_i, pnl_data_i}.
- wen=1 for load. Load and look in the same cycle: load wins, look dropped.
- Pulses are ignored while the buffer is full or pnl_en_i=0.
- pnl_busy_o=1 from the cycle after capture until pnl_done_o.

FSM states: IDLE, CORE, PANEL.
- IDLE with both requesting: grant PANEL if starve count ≥ STARVE_LIMIT, else CORE. With one requesting, grant it. With none, stay in IDLE.
- Grant takes effect on the next edge: one-cycle arbitration bubble.
- CORE: mem_* = core_* inputs, mem_val_o=1. On mem_rdy_i, core_rdy_o=1 combinationally that cycle and core_rdata_o=mem_rdata_i, then go to IDLE.
- PANEL: mem_* driven from the buffer, mem_val_o=1. On mem_rdy_i, register pnl_rdata_o (mem_rdata_i if look, buffered data if load), pulse pnl_done_o next cycle, clear the buffer, then go to IDLE.
- Starve count: +1 (saturating) on each CORE grant while the buffer is full; cleared on a PANEL grant and whenever the buffer is empty.
- mem_val_o=0 in IDLE; mem_wen_o/addr/wdata are 0 in IDLE.
- core_rdy_o is never asserted outside CORE.
- core_val_i dropping while in CORE is a protocol violation; behaviour is undefined, and the bench asserts against it.
- No preemption: a grant is held until mem_rdy_i.
- Back-to-back core requests each incur one IDLE bubble.

Test Plan:
- Panel load only: pnl_en_i=1, pulse pnl_load_i with addr=0x10, data=0xBEEF; mem_rdy_i 2 cycles after mem_val_o -> one write to 0x10; pnl_done_o one cycle after rdy; pnl_rdata_o=0xBEEF; pnl_busy_o high throughout the transaction.
- Panel look: memory[0x10]=0xBEEF, pulse pnl_look_i with addr=0x10 -> mem_wen_o=0; pnl_rdata_o=0xBEEF.
- Core continuous reads with the panel pending: core_val_i held high, panel look pending -> exactly 4 core grants, then PANEL, then core resumes; starve count back to 0.
- Simultaneous load+look pulse, then a second pulse while busy -> only the load (wen=1) is performed; the second pulse is ignored; exactly one pnl_done_o.
- Gating: pnl_en_i=0 with a load pulse -> no capture, pnl_busy_o stays 0, no memory access.
- Reset mid-PANEL: rst_i=1 while mem_val_o=1 -> next cycle mem_val_o=0 and pnl_busy_o=0; a late mem_rdy_i produces neither pnl_done_o nor core_rdy_o.

Source files
------------

// File: rtl/mem_rw_arbiter.sv
`timescale 1ns/1ps
// mem_rw_arbiter
// Shares the single read/write port of main_mem between the core load/store
// path and the front-panel LOAD/LOOK buttons.
//
// A one-entry buffer latches a panel button pulse. A registered grant FSM
// (IDLE/CORE/PANEL) then hands the memory port to one requester at a time.
// A grant is held until main_mem answers with mem_rdy_i. Every grant passes
// through IDLE, so each transaction costs one arbitration bubble. A starve
// counter forces a panel grant once the core has won STARVE_LIMIT arbitrations
// while the panel waited.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   core_*_i / core_*_o core request (val/wen/addr/wdata), rdata + rdy pulse
//   pnl_en_i            panel access permitted
//   pnl_load_i/look_i   button pulses (load = write, look = read)
//   pnl_addr_i/data_i   address / data switches
//   pnl_busy_o          panel request buffered or in service
//   pnl_done_o          one-cycle pulse after a panel transaction completes
//   pnl_rdata_o         last panel result (read data for look, written data for load)
//   mem_*_o / mem_*_i   single request port to main_mem, rdy pulse from main_mem
module mem_rw_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          core_val_i,
  input  logic          core_wen_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic [DW-1:0] core_rdata_o,
  output logic          core_rdy_o,
  input  logic          pnl_en_i,
  input  logic          pnl_load_i,
  input  logic          pnl_look_i,
  input  logic [AW-1:0] pnl_addr_i,
  input  logic [DW-1:0] pnl_data_i,
  output logic          pnl_busy_o,
  output logic          pnl_done_o,
  output logic [DW-1:0] pnl_rdata_o,
  output logic          mem_val_o,
  output logic          mem_wen_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_rdy_i
);

  // Counter wide enough to hold STARVE_LIMIT itself, so it can saturate there.
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CORE  = 2'd1,
    ST_PANEL = 2'd2
  } state_t;

  state_t        state_r;
  logic          buf_full_r;
  logic          buf_wen_r;
  logic [AW-1:0] buf_addr_r;
  logic [DW-1:0] buf_data_r;
  logic [SW-1:0] starve_r;
  logic          pnl_done_r;
  logic [DW-1:0] pnl_rdata_r;

  logic          capture_s;
  logic          panel_fin_s;

  // A pulse is accepted only into an empty buffer. Pulses seen while the
  // buffer is occupied are dropped, not queued.
  assign capture_s   = pnl_en_i & ~buf_full_r & (pnl_load_i | pnl_look_i);
  assign panel_fin_s = (state_r == ST_PANEL) & mem_rdy_i;

  assign pnl_busy_o  = buf_full_r;
  assign pnl_done_o  = pnl_done_r;
  assign pnl_rdata_o = pnl_rdata_r;

  // Panel request buffer: capture a button pulse, release it when the panel
  // transaction completes. Load wins over look in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_full_r <= 1'b0;
      buf_wen_r  <= 1'b0;
      buf_addr_r <= {AW{1'b0}};
      buf_data_r <= {DW{1'b0}};
    end else if (panel_fin_s) begin
      buf_full_r <= 1'b0;
    end else if (capture_s) begin
      buf_full_r <= 1'b1;
      buf_wen_r  <= pnl_load_i;
      buf_addr_r <= pnl_addr_i;
      buf_data_r <= pnl_data_i;
    end else begin
      buf_full_r <= buf_full_r;
    end
  end

  // Grant FSM with starvation counter and the registered panel result/done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      starve_r    <= {SW{1'b0}};
      pnl_done_r  <= 1'b0;
      pnl_rdata_r <= {DW{1'b0}};
    end else begin
      pnl_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (buf_full_r && (!core_val_i || (starve_r >= STARVE_MAX))) begin
            state_r  <= ST_PANEL;
            starve_r <= {SW{1'b0}};
          end else if (core_val_i) begin
            state_r <= ST_CORE;
            // Only core wins taken while the panel waits count toward forcing it.
            if (!buf_full_r) begin
              starve_r <= {SW{1'b0}};
            end else if (starve_r < STARVE_MAX) begin
              starve_r <= starve_r + STARVE_ONE;
            end else begin
              starve_r <= starve_r;
            end
          end else begin
            state_r  <= ST_IDLE;
            starve_r <= {SW{1'b0}};
          end
        end
        ST_CORE: begin
          if (!buf_full_r) begin
            starve_r <= {SW{1'b0}};
          end else begin
            starve_r <= starve_r;
          end
          if (mem_rdy_i) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_CORE;
          end
        end
        ST_PANEL: begin
          starve_r <= {SW{1'b0}};
          if (mem_rdy_i) begin
            state_r     <= ST_IDLE;
            pnl_done_r  <= 1'b1;
            pnl_rdata_r <= buf_wen_r ? buf_data_r : mem_rdata_i;
          end else begin
            state_r <= ST_PANEL;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          starve_r <= {SW{1'b0}};
        end
      endcase
    end
  end

  // Memory port mux: the granted requester drives main_mem. All fields are zero in IDLE.
  always_comb begin
    mem_val_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = {AW{1'b0}};
    mem_wdata_o = {DW{1'b0}};
    case (state_r)
      ST_CORE: begin
        mem_val_o   = 1'b1;
        mem_wen_o   = core_wen_i;
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
      end
      ST_PANEL: begin
        mem_val_o   = 1'b1;
        mem_wen_o   = buf_wen_r;
        mem_addr_o  = buf_addr_r;
        mem_wdata_o = buf_data_r;
      end
      default: begin
        mem_val_o = 1'b0;
      end
    endcase
  end

  // Core completion passes main_mem's pulse straight through, only while the core holds the grant.
  always_comb begin
    core_rdy_o   = 1'b0;
    core_rdata_o = {DW{1'b0}};
    if (state_r == ST_CORE) begin
      core_rdy_o   = mem_rdy_i;
      core_rdata_o = mem_rdata_i;
    end else begin
      core_rdy_o   = 1'b0;
      core_rdata_o = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_rw_arbiter.sv
`timescale 1ns/1ps
module tb_mem_rw_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_val_i, core_wen_i;
  logic [7:0]  core_addr_i;
  logic [15:0] core_wdata_i, core_rdata_o;
  logic        core_rdy_o;
  logic        pnl_en_i, pnl_load_i, pnl_look_i;
  logic [7:0]  pnl_addr_i;
  logic [15:0] pnl_data_i, pnl_rdata_o;
  logic        pnl_busy_o, pnl_done_o;
  logic        mem_val_o, mem_wen_o;
  logic [7:0]  mem_addr_o;
  logic [15:0] mem_wdata_o, mem_rdata_i;
  logic        mem_rdy_i;

  // Memory model state
  logic [15:0] mem [0:255];
  logic [8:0]  log_q [$];
  logic        model_rdy, manual_rdy, model_en;
  int          lat, cnt;
  bit          inited = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        en, load, look;
    logic [7:0]  addr;
    logic [15:0] data;
    int          lat;
    int          exp_acc;
    logic        exp_wen;
    logic [15:0] exp_rdata;
    int          p2_at;
    logic [7:0]  p2_addr;
    logic [15:0] p2_data;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  assign mem_rdy_i = model_rdy | manual_rdy;

  always #5 clk_i = ~clk_i;

  mem_rw_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_val_i(core_val_i), .core_wen_i(core_wen_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o), .core_rdy_o(core_rdy_o),
    .pnl_en_i(pnl_en_i), .pnl_load_i(pnl_load_i), .pnl_look_i(pnl_look_i),
    .pnl_addr_i(pnl_addr_i), .pnl_data_i(pnl_data_i), .pnl_busy_o(pnl_busy_o),
    .pnl_done_o(pnl_done_o), .pnl_rdata_o(pnl_rdata_o),
    .mem_val_o(mem_val_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_rdy_i(mem_rdy_i)
  );

  // The core must hold its request until it is completed
  assert property (@(posedge clk_i) disable iff (rst_i)
                   (core_val_i && !core_rdy_o) |=> core_val_i)
    else $error("core_val_i dropped before core_rdy_o");

  // main_mem model: answers lat cycles after mem_val_o is first seen, logs {wen,addr}
  always @(negedge clk_i) begin
    if (!inited) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      model_rdy   = 1'b0;
      mem_rdata_i = 16'h0000;
      cnt         = 0;
      inited      = 1'b1;
    end else if (!model_en || model_rdy) begin
      model_rdy = 1'b0;
      cnt       = 0;
    end else if (mem_val_o) begin
      if (cnt >= lat) begin
        model_rdy   = 1'b1;
        mem_rdata_i = mem[mem_addr_o];
        log_q.push_back({mem_wen_o, mem_addr_o});
        if (mem_wen_o) mem[mem_addr_o] = mem_wdata_o;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // One panel transaction from a vector: pulse, optional second pulse, 20-cycle window
  task automatic run_vec(input vec_t v, input string tag);
    int         base, done_cnt;
    logic       done_ok, busy_ok, rdy_prev, wen_seen;
    logic [7:0] addr_seen;
    base = log_q.size();
    done_cnt = 0; done_ok = 1'b1; busy_ok = 1'b1; rdy_prev = 1'b0;
    wen_seen = 1'b0; addr_seen = 8'h00;
    lat = v.lat;
    pnl_en_i = v.en; pnl_load_i = v.load; pnl_look_i = v.look;
    pnl_addr_i = v.addr; pnl_data_i = v.data;
    step();
    for (int c = 0; c < 20; c++) begin
      if (pnl_done_o) done_cnt++;
      if (pnl_done_o !== rdy_prev) done_ok = 1'b0;
      if ((mem_val_o || (c == 0 && v.exp_acc != 0)) && !pnl_busy_o) busy_ok = 1'b0;
      if (mem_val_o) begin
        wen_seen  = mem_wen_o;
        addr_seen = mem_addr_o;
      end
      rdy_prev = mem_rdy_i & mem_val_o;
      if (c == v.p2_at) begin
        pnl_load_i = 1'b1; pnl_look_i = 1'b0;
        pnl_addr_i = v.p2_addr; pnl_data_i = v.p2_data;
      end else begin
        pnl_load_i = 1'b0; pnl_look_i = 1'b0;
      end
      step();
    end
    pnl_en_i = 1'b1;
    chk({tag, "_accesses"}, log_q.size() - base, v.exp_acc);
    chk({tag, "_done_count"}, done_cnt, v.exp_acc);
    chk({tag, "_done_timing"}, {31'd0, done_ok}, 32'd1);
    chk({tag, "_rdata"}, {16'd0, pnl_rdata_o}, {16'd0, v.exp_rdata});
    chk({tag, "_busy_end"}, {31'd0, pnl_busy_o}, 32'd0);
    if (v.exp_acc != 0) begin
      chk({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
      chk({tag, "_wen"}, {31'd0, wen_seen}, {31'd0, v.exp_wen});
      chk({tag, "_addr"}, {24'd0, addr_seen}, {24'd0, v.addr});
    end
  endtask

  int          guard, base, n_pre;
  logic        rd_ok, pw_ok, prev_rdy, wr_wen;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  vec_t        vb;

  initial begin
    rst_i = 1'b1; core_val_i = 1'b0; core_wen_i = 1'b0; core_addr_i = 8'h00;
    core_wdata_i = 16'h0000; pnl_en_i = 1'b0; pnl_load_i = 1'b0; pnl_look_i = 1'b0;
    pnl_addr_i = 8'h00; pnl_data_i = 16'h0000; manual_rdy = 1'b0; model_en = 1'b1; lat = 1;

    //           en    load  look  addr   data      lat acc wen   rdata     p2  p2a    p2d
    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h10, 16'hBEEF, 2,  1,  1'b1, 16'hBEEF, -1, 8'h00, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h10, 16'hDEAD, 1,  1,  1'b0, 16'hBEEF, -1, 8'h00, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h11, 16'h1234, 3,  1,  1'b1, 16'h1234, -1, 8'h00, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h12, 16'h5555, 1,  0,  1'b0, 16'h1234, -1, 8'h00, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h12, 16'hFFFF, 1,  1,  1'b0, 16'h0000, -1, 8'h00, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h11, 16'h0000, 2,  1,  1'b0, 16'h1234, -1, 8'h00, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h20, 16'h2222, 1,  1,  1'b1, 16'h2222, -1, 8'h00, 16'h0000};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 8'h30, 16'hC0DE, 1,  1,  1'b1, 16'hC0DE, -1, 8'h00, 16'h0000};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 8'hFF, 16'hA5A5, 1,  1,  1'b1, 16'hA5A5, -1, 8'h00, 16'h0000};

    repeat (3) step();
    chk("rst_mem_val", {31'd0, mem_val_o}, 32'd0);
    chk("rst_core_rdy", {31'd0, core_rdy_o}, 32'd0);
    chk("rst_busy", {31'd0, pnl_busy_o}, 32'd0);
    chk("rst_done", {31'd0, pnl_done_o}, 32'd0);
    chk("rst_pnl_rdata", {16'd0, pnl_rdata_o}, 32'd0);
    chk("rst_mem_fields", {7'd0, mem_wen_o, mem_addr_o, mem_wdata_o}, 32'd0);
    rst_i = 1'b0; pnl_en_i = 1'b1;
    step();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Load+look together, then a second load pulse while the first is in service
    vb = '{1'b1, 1'b1, 1'b1, 8'h40, 16'h7777, 3, 1, 1'b1, 16'h7777, 2, 8'h41, 16'h9999};
    run_vec(vb, "busy_pulse");
    chk("busy_pulse_mem40", {16'd0, mem[8'h40]}, {16'd0, 16'h7777});
    chk("busy_pulse_mem41", {16'd0, mem[8'h41]}, 32'd0);

    // Core reads held continuously while the panel waits: four core wins, then panel
    lat = 1; core_wen_i = 1'b0; core_addr_i = 8'h20; core_val_i = 1'b1;
    rd_ok = 1'b1; pw_ok = 1'b1;
    for (int r = 0; r < 2; r++) begin
      guard = 0;
      while (!core_rdy_o && guard < 50) begin step(); guard++; end
      chk($sformatf("starve%0d_first_rdy", r), {31'd0, core_rdy_o}, 32'd1);
      pnl_look_i = 1'b1; pnl_addr_i = 8'h30;
      base = log_q.size();
      step();
      pnl_look_i = 1'b0;
      guard = 0; prev_rdy = 1'b0;
      while (log_q.size() < base + 6 && guard < 100) begin
        if (core_rdy_o && core_rdata_o !== 16'h2222) rd_ok = 1'b0;
        if (core_rdy_o && prev_rdy) pw_ok = 1'b0;
        prev_rdy = core_rdy_o;
        step();
        guard++;
      end
      n_pre = 0;
      for (int i = base; i < log_q.size() && log_q[i][7:0] != 8'h30; i++) n_pre++;
      chk($sformatf("starve%0d_core_grants", r), n_pre, 4);
      chk($sformatf("starve%0d_panel_slot", r),
          (log_q.size() > base + 4) ? {23'd0, log_q[base+4]} : 32'h1FF, 32'h030);
      chk($sformatf("starve%0d_core_resumes", r),
          (log_q.size() > base + 5) ? {23'd0, log_q[base+5]} : 32'h1FF, 32'h020);
      chk($sformatf("starve%0d_look_rdata", r), {16'd0, pnl_rdata_o}, 32'hC0DE);
    end
    step();
    core_val_i = 1'b0;
    chk("starve_core_rdata", {31'd0, rd_ok}, 32'd1);
    chk("starve_rdy_single", {31'd0, pw_ok}, 32'd1);
    step(); step();
    chk("starve_idle_after", {31'd0, mem_val_o}, 32'd0);

    // Core write then back-to-back read of the same word
    lat = 2; core_wen_i = 1'b1; core_addr_i = 8'h50; core_wdata_i = 16'h1357; core_val_i = 1'b1;
    guard = 0; wr_wen = 1'b0; wr_data = 16'h0000; wr_addr = 8'h00;
    while (!core_rdy_o && guard < 50) begin
      if (mem_val_o) begin wr_wen = mem_wen_o; wr_data = mem_wdata_o; wr_addr = mem_addr_o; end
      step();
      guard++;
    end
    chk("core_wr_rdy", {31'd0, core_rdy_o}, 32'd1);
    chk("core_wr_fields", {7'd0, wr_wen, wr_addr, wr_data}, {7'd0, 1'b1, 8'h50, 16'h1357});
    step();
    chk("core_bubble", {7'd0, mem_val_o, mem_addr_o, mem_wdata_o}, 32'd0);
    core_wen_i = 1'b0;
    guard = 0;
    while (!core_rdy_o && guard < 50) begin step(); guard++; end
    chk("core_rd_rdy", {31'd0, core_rdy_o}, 32'd1);
    chk("core_rd_data", {16'd0, core_rdata_o}, 32'h1357);
    chk("core_wr_mem", {16'd0, mem[8'h50]}, 32'h1357);
    step();
    core_val_i = 1'b0;
    step();

    // Reset in the middle of a panel transaction, then a late mem_rdy_i
    model_en = 1'b0;
    pnl_look_i = 1'b1; pnl_addr_i = 8'h60;
    step();
    pnl_look_i = 1'b0;
    guard = 0;
    while (!mem_val_o && guard < 10) begin step(); guard++; end
    chk("rst_mid_val_pre", {31'd0, mem_val_o}, 32'd1);
    step();
    rst_i = 1'b1;
    step();
    chk("rst_mid_val", {31'd0, mem_val_o}, 32'd0);
    chk("rst_mid_busy", {31'd0, pnl_busy_o}, 32'd0);
    chk("rst_mid_rdata", {16'd0, pnl_rdata_o}, 32'd0);
    rst_i = 1'b0; manual_rdy = 1'b1;
    step();
    chk("late_rdy_core_rdy", {31'd0, core_rdy_o}, 32'd0);
    chk("late_rdy_done0", {31'd0, pnl_done_o}, 32'd0);
    manual_rdy = 1'b0;
    step();
    chk("late_rdy_done1", {31'd0, pnl_done_o}, 32'd0);
    chk("late_rdy_idle", {30'd0, mem_val_o, pnl_busy_o}, 32'd0);
    model_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
